rv32_mem_arbiter: RTL and testbench

- Shares one pipelined Avalon-MM memory port between the RV32I core's instruction fetch port and its data load/store port.
- Sits between the core and a unified RAM or bus fabric.
- To the core it presents two waitrequest-style slave ports; to memory it presents one master port with readdatavalid.
- Arbitration uses data-first priority with a bounded streak, so instruction fetch is never starved.

---
 rtl/rv32_mem_arb_pkg.sv | 30 +++
 rtl/rv32_mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_rv32_mem_arbiter.sv | 387 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32_mem_arb_pkg.sv
// ============================================================================
// Module   : rv32_mem_arb_pkg
// Brief    : Shared state encoding and constants for the RV32 memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32_mem_arb_pkg;

    localparam int STREAK_W = 4;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_IRD  = 3'd1;
    localparam logic [2:0] ST_IRDW = 3'd2;
    localparam logic [2:0] ST_DRD  = 3'd3;
    localparam logic [2:0] ST_DRDW = 3'd4;
    localparam logic [2:0] ST_DWR  = 3'd5;

    typedef enum logic [2:0] {
        IDLE = ST_IDLE,
        IRD  = ST_IRD,
        IRDW = ST_IRDW,
        DRD  = ST_DRD,
        DRDW = ST_DRDW,
        DWR  = ST_DWR
    } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/rv32_mem_arbiter.sv
// ============================================================================
// Module   : rv32_mem_arbiter
// Brief    : Shares one pipelined Avalon-MM port between RV32 fetch and data
//            ports; data-first priority with a bounded streak for fetch.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv32_mem_arbiter
    import rv32_mem_arb_pkg::*;
#(
    parameter int DATA_BURST_MAX = 4,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [ADDR_W-1:0] iaddress,
    input  logic              iread,
    output logic [31:0]       ireaddata,
    output logic              iwaitrequest,

    input  logic [ADDR_W-1:0] daddress,
    input  logic              dread,
    input  logic              dwrite,
    input  logic [31:0]       dwritedata,
    input  logic [3:0]        dbyteenable,
    output logic [31:0]       dreaddata,
    output logic              dwaitrequest,

    output logic [ADDR_W-1:0] maddress,
    output logic              mread,
    output logic              mwrite,
    output logic [31:0]       mwritedata,
    output logic [3:0]        mbyteenable,
    input  logic [31:0]       mreaddata,
    input  logic              mwaitrequest,
    input  logic              mreaddatavalid
);

    localparam logic [STREAK_W-1:0] C_BURST_MAX = STREAK_W'(DATA_BURST_MAX);

    arb_state_e          state_q, state_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic [ADDR_W-1:0]   maddress_q, maddress_d;
    logic [31:0]         mwritedata_q, mwritedata_d;
    logic [3:0]          mbyteenable_q, mbyteenable_d;

    logic w_idle;
    logic w_fetch_forced;
    logic w_grant_d;
    logic w_grant_i;

    assign w_idle         = (state_q == IDLE);
    assign w_fetch_forced = iread && (streak_q == C_BURST_MAX);
    assign w_grant_d      = w_idle && (dread || dwrite) && !w_fetch_forced;
    assign w_grant_i      = w_idle && iread && !w_grant_d;

    always_comb begin
        state_d       = state_q;
        streak_d      = streak_q;
        maddress_d    = maddress_q;
        mwritedata_d  = mwritedata_q;
        mbyteenable_d = mbyteenable_q;
        iwaitrequest  = 1'b1;
        dwaitrequest  = 1'b1;
        ireaddata     = '0;
        dreaddata     = '0;

        case (state_q)
            IDLE: begin
                if (w_grant_d) begin
                    maddress_d = daddress;
                    if (dwrite) begin
                        state_d       = DWR;
                        mwritedata_d  = dwritedata;
                        mbyteenable_d = dbyteenable;
                    end else begin
                        state_d       = DRD;
                        mbyteenable_d = 4'hF;
                    end
                end else if (w_grant_i) begin
                    state_d       = IRD;
                    maddress_d    = iaddress;
                    mbyteenable_d = 4'hF;
                end
            end
            // Zero-latency memory may return data in the accept cycle.
            IRD: begin
                if (!mwaitrequest) begin
                    if (mreaddatavalid) begin
                        iwaitrequest = 1'b0;
                        ireaddata    = mreaddata;
                        state_d      = IDLE;
                    end else begin
                        state_d = IRDW;
                    end
                end
            end
            IRDW: begin
                if (mreaddatavalid) begin
                    iwaitrequest = 1'b0;
                    ireaddata    = mreaddata;
                    state_d      = IDLE;
                end
            end
            DRD: begin
                if (!mwaitrequest) begin
                    if (mreaddatavalid) begin
                        dwaitrequest = 1'b0;
                        dreaddata    = mreaddata;
                        state_d      = IDLE;
                    end else begin
                        state_d = DRDW;
                    end
                end
            end
            DRDW: begin
                if (mreaddatavalid) begin
                    dwaitrequest = 1'b0;
                    dreaddata    = mreaddata;
                    state_d      = IDLE;
                end
            end
            DWR: begin
                if (!mwaitrequest) begin
                    dwaitrequest = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Streak counts data wins only while a fetch is actually waiting.
        if (!iread || w_grant_i) begin
            streak_d = '0;
        end else if (w_grant_d && (streak_q != C_BURST_MAX)) begin
            streak_d = streak_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            streak_q      <= '0;
            maddress_q    <= '0;
            mwritedata_q  <= '0;
            mbyteenable_q <= '0;
        end else begin
            state_q       <= state_d;
            streak_q      <= streak_d;
            maddress_q    <= maddress_d;
            mwritedata_q  <= mwritedata_d;
            mbyteenable_q <= mbyteenable_d;
        end
    end

    assign mread       = (state_q == IRD) || (state_q == DRD);
    assign mwrite      = (state_q == DWR);
    assign maddress    = maddress_q;
    assign mwritedata  = mwritedata_q;
    assign mbyteenable = mbyteenable_q;

endmodule

`default_nettype wire

// File: tb/tb_rv32_mem_arbiter.sv
// ============================================================================
// Module   : tb_rv32_mem_arbiter
// Brief    : Self-checking bench for rv32_mem_arbiter with a memory responder
//            and a behavioural arbitration/memory reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv32_mem_arbiter;

    localparam int MAX = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] iaddress, daddress, dwritedata, maddress, mwritedata, mreaddata;
    logic [31:0] ireaddata, dreaddata;
    logic        iread, iwaitrequest, dread, dwrite, dwaitrequest;
    logic [3:0]  dbyteenable, mbyteenable;
    logic        mread, mwrite, mwaitrequest, mreaddatavalid;

    rv32_mem_arbiter #(.DATA_BURST_MAX(MAX), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .iaddress(iaddress), .iread(iread), .ireaddata(ireaddata), .iwaitrequest(iwaitrequest),
        .daddress(daddress), .dread(dread), .dwrite(dwrite), .dwritedata(dwritedata),
        .dbyteenable(dbyteenable), .dreaddata(dreaddata), .dwaitrequest(dwaitrequest),
        .maddress(maddress), .mread(mread), .mwrite(mwrite), .mwritedata(mwritedata),
        .mbyteenable(mbyteenable), .mreaddata(mreaddata), .mwaitrequest(mwaitrequest),
        .mreaddatavalid(mreaddatavalid)
    );

    always #5 clk = ~clk;

    typedef struct { bit rd; bit wr; logic [31:0] addr; logic [31:0] data; logic [3:0] be; bit acc; int c; } strobe_t;
    typedef struct { bit is_d; logic [31:0] data; int c; } comp_t;
    typedef struct { logic [31:0] got; logic [31:0] exp; bit chk; int cdone; } res_t;

    strobe_t strobe_q[$];
    comp_t   comp_q[$];
    res_t    fres[$];
    res_t    dres[$];

    logic [31:0] rmem [logic [31:0]];
    logic [31:0] gmem [logic [31:0]];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int bad_rdata = 0;
    int both_low  = 0;

    int cfg_wait = 0;
    int cfg_lat  = 1;
    bit rand_timing = 0;
    bit stray = 0;
    bit cmd_busy = 0;
    int cur_wait, cur_lat, waited;
    bit pend_v = 0;
    int pend_due;
    logic [31:0] pend_addr;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] rmem_rd(input logic [31:0] a);
        return rmem.exists(a) ? rmem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] gread(input logic [31:0] a);
        return gmem.exists(a) ? gmem[a] : init_word(a);
    endfunction

    // Memory responder: drives the slave side for the cycle that follows.
    always @(negedge clk) begin
        cyc = cyc + 1;
        mwaitrequest   = 1'b0;
        mreaddatavalid = 1'b0;
        mreaddata      = 32'(cyc) ^ 32'hBAD0_0000;
        if (reset) begin
            cmd_busy = 0;
        end else if (mread || mwrite) begin
            if (!cmd_busy) begin
                cmd_busy = 1;
                waited   = 0;
                cur_wait = rand_timing ? int'($urandom_range(0, 2)) : cfg_wait;
                cur_lat  = rand_timing ? int'($urandom_range(0, 3)) : cfg_lat;
            end
            if (waited < cur_wait) begin
                mwaitrequest = 1'b1;
                waited++;
            end else begin
                cmd_busy = 0;
                if (mwrite) rmem[maddress] = merge(rmem_rd(maddress), mwritedata, mbyteenable);
                else begin
                    pend_v    = 1;
                    pend_due  = cyc + cur_lat;
                    pend_addr = maddress;
                end
            end
        end
        if (pend_v && pend_due == cyc) begin
            mreaddatavalid = 1'b1;
            mreaddata      = rmem_rd(pend_addr);
            pend_v         = 0;
        end
        if (stray) begin
            mreaddatavalid = 1'b1;
            mreaddata      = 32'hFEED_F00D;
            stray          = 0;
        end
    end

    always @(negedge clk) begin
        #2;
        if (mread || mwrite)
            strobe_q.push_back('{mread, mwrite, maddress, mwritedata, mbyteenable, !mwaitrequest, cyc});
        if (!iwaitrequest) comp_q.push_back('{1'b0, ireaddata, cyc});
        if (!dwaitrequest) comp_q.push_back('{1'b1, dreaddata, cyc});
        if ((iwaitrequest && ireaddata != 32'd0) || (dwaitrequest && dreaddata != 32'd0)) bad_rdata++;
        if (!iwaitrequest && !dwaitrequest) both_low++;
    end

    task automatic wait_done(input bit is_d, output int cdone, output logic [31:0] rdata);
        cdone = -1;
        rdata = '0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk); #2;
            if (is_d ? !dwaitrequest : !iwaitrequest) begin
                cdone = cyc;
                rdata = is_d ? dreaddata : ireaddata;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic run_one(input bit is_d, input bit rd, input bit wr, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] be,
                           output int c0, output int cdone, output logic [31:0] rdata);
        c0 = cyc + 1;
        if (is_d) begin
            daddress = a; dread = rd; dwrite = wr; dwritedata = wd; dbyteenable = be;
        end else begin
            iaddress = a; iread = 1'b1;
        end
        wait_done(is_d, cdone, rdata);
        iread = 1'b0; dread = 1'b0; dwrite = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        iread = 0; dread = 0; dwrite = 0; iaddress = 0; daddress = 0; dwritedata = 0; dbyteenable = 0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (mread !== 1'b0 || mwrite !== 1'b0) begin n_fail++; $display("FAIL reset_strobes: got rd=%b wr=%b want 0 0", mread, mwrite); end
        n_checks++; if (maddress !== 32'd0 || mwritedata !== 32'd0 || mbyteenable !== 4'd0) begin n_fail++; $display("FAIL reset_cmd_regs: got a=%h d=%h be=%h want zeros", maddress, mwritedata, mbyteenable); end
        n_checks++; if (iwaitrequest !== 1'b1 || dwaitrequest !== 1'b1) begin n_fail++; $display("FAIL reset_waitreq: got i=%b d=%b want 1 1", iwaitrequest, dwaitrequest); end
        reset = 1'b0;
        @(posedge clk); #1;
        comp_q.delete(); strobe_q.delete();
        stray = 1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (comp_q.size() != 0 || strobe_q.size() != 0) begin n_fail++; $display("FAIL stray_rdv_idle: got completions=%0d strobes=%0d want 0 0", comp_q.size(), strobe_q.size()); end
    endtask

    task automatic test_fetch();
        int c0, cdone, w, l;
        logic [31:0] rd, a;
        cfg_wait = 0; cfg_lat = 2;
        rmem[32'h100] = 32'h0000_0013;
        comp_q.delete(); strobe_q.delete();
        run_one(0, 1, 0, 32'h100, 0, 0, c0, cdone, rd);
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (cdone !== c0 + 3) begin n_fail++; $display("FAIL fetch_latency: got cycle %0d want %0d", cdone, c0 + 3); end
        n_checks++; if (rd !== 32'h0000_0013) begin n_fail++; $display("FAIL fetch_data: got %h want 00000013", rd); end
        n_checks++; if (comp_q.size() != 1) begin n_fail++; $display("FAIL fetch_once: got %0d completions want 1", comp_q.size()); end
        n_checks++; if (strobe_q.size() != 1 || !strobe_q[0].rd || strobe_q[0].addr !== 32'h100 || strobe_q[0].be !== 4'hF) begin
            n_fail++; $display("FAIL fetch_cmd: got %0d strobe cycles want 1 read at 00000100 be=F", strobe_q.size()); end
        for (int k = 0; k < 5; k++) begin
            w = int'($urandom_range(0, 3)); l = int'($urandom_range(0, 3));
            cfg_wait = w; cfg_lat = l;
            a = 32'h200 + 32'd4 * $urandom_range(0, 63);
            run_one(0, 1, 0, a, 0, 0, c0, cdone, rd);
            n_checks++; if (cdone !== c0 + 1 + w + l || rd !== init_word(a)) begin
                n_fail++; $display("FAIL fetch_rand: got cycle %0d data %h want cycle %0d data %h", cdone, rd, c0 + 1 + w + l, init_word(a)); end
        end
    endtask

    task automatic test_store();
        int c0, cdone;
        logic [31:0] rd, expw;
        bit hold_ok;
        cfg_wait = 2; cfg_lat = 1;
        comp_q.delete(); strobe_q.delete();
        expw = merge(gread(32'h2004), 32'hDEAD_BEEF, 4'b0011);
        gmem[32'h2004] = expw;
        run_one(1, 0, 1, 32'h2004, 32'hDEAD_BEEF, 4'b0011, c0, cdone, rd);
        hold_ok = 1;
        foreach (strobe_q[i])
            if (!strobe_q[i].wr || strobe_q[i].addr !== 32'h2004 || strobe_q[i].data !== 32'hDEAD_BEEF || strobe_q[i].be !== 4'b0011) hold_ok = 0;
        n_checks++; if (strobe_q.size() != 3) begin n_fail++; $display("FAIL store_mwrite_len: got %0d cycles want 3", strobe_q.size()); end
        n_checks++; if (!hold_ok) begin n_fail++; $display("FAIL store_cmd_hold: got changing/wrong addr/data/be want 00002004/deadbeef/3"); end
        n_checks++; if (cdone !== c0 + 3) begin n_fail++; $display("FAIL store_latency: got cycle %0d want %0d", cdone, c0 + 3); end
        n_checks++; if (rmem_rd(32'h2004) !== expw) begin n_fail++; $display("FAIL store_memory: got %h want %h", rmem_rd(32'h2004), expw); end
    endtask

    task automatic test_back_to_back();
        int c0, cdone, w, l;
        logic [31:0] rd, a, wd, expd;
        logic [3:0] be;
        bit is_wr;
        for (int k = 0; k < 10; k++) begin
            w = int'($urandom_range(0, 3)); l = int'($urandom_range(0, 3));
            cfg_wait = w; cfg_lat = l;
            a  = 32'h2000 + 32'd4 * $urandom_range(0, 7);
            wd = $urandom;
            be = 4'($urandom_range(1, 15));
            is_wr = ($urandom_range(0, 1) == 1);
            if (is_wr) gmem[a] = merge(gread(a), wd, be);
            expd = is_wr ? 32'd0 : gread(a);
            run_one(1, !is_wr, is_wr, a, wd, be, c0, cdone, rd);
            n_checks++; if (cdone !== c0 + 1 + w + (is_wr ? 0 : l)) begin
                n_fail++; $display("FAIL data_latency: got cycle %0d want %0d (wr=%0b)", cdone, c0 + 1 + w + (is_wr ? 0 : l), is_wr); end
            if (!is_wr) begin
                n_checks++; if (rd !== expd) begin n_fail++; $display("FAIL data_load: addr %h got %h want %h", a, rd, expd); end
            end
        end
    endtask

    task automatic test_dual_request();
        int c1, c2;
        logic [31:0] r1, r2, a, wd, expw;
        logic [3:0] be;
        strobe_t acc[$];
        cfg_wait = 0; cfg_lat = 1;
        a = 32'h2010; wd = $urandom; be = 4'($urandom_range(1, 14));
        expw = merge(gread(a), wd, be);
        gmem[a] = expw;
        comp_q.delete(); strobe_q.delete();
        daddress = a; dwritedata = wd; dbyteenable = be; dread = 1; dwrite = 1;
        wait_done(1, c1, r1);
        dwrite = 0;
        wait_done(1, c2, r2);
        dread = 0;
        foreach (strobe_q[i]) if (strobe_q[i].acc) acc.push_back(strobe_q[i]);
        n_checks++; if (acc.size() != 2) begin n_fail++; $display("FAIL dual_cmd_count: got %0d want 2", acc.size()); end
        else begin
            n_checks++; if (!acc[0].wr || acc[0].data !== wd || !acc[1].rd || acc[1].be !== 4'hF) begin
                n_fail++; $display("FAIL dual_order: got first wr=%0b second rd=%0b be=%h want write then read be=F", acc[0].wr, acc[1].rd, acc[1].be); end
        end
        n_checks++; if (r2 !== expw || c1 < 0 || c2 < 0) begin n_fail++; $display("FAIL dual_readback: got %h want %h", r2, expw); end
    endtask

    task automatic test_zero_latency();
        int c0, cdone;
        logic [31:0] rd;
        cfg_wait = 0; cfg_lat = 0;
        strobe_q.delete();
        run_one(0, 1, 0, 32'h300, 0, 0, c0, cdone, rd);
        n_checks++; if (cdone !== c0 + 1 || rd !== init_word(32'h300)) begin
            n_fail++; $display("FAIL zero_lat_fetch: got cycle %0d data %h want %0d %h", cdone, rd, c0 + 1, init_word(32'h300)); end
        n_checks++; if (strobe_q.size() != 1) begin n_fail++; $display("FAIL zero_lat_mread: got %0d cycles want 1", strobe_q.size()); end
        run_one(1, 1, 0, 32'h2018, 0, 0, c0, cdone, rd);
        n_checks++; if (cdone !== c0 + 1 || rd !== gread(32'h2018)) begin
            n_fail++; $display("FAIL zero_lat_load: got cycle %0d data %h want %0d %h", cdone, rd, c0 + 1, gread(32'h2018)); end
    endtask

    task automatic fetch_thread(input int n);
        int cdone;
        logic [31:0] a, rd;
        for (int k = 0; k < n; k++) begin
            a = 32'h400 + 32'd4 * k;
            iaddress = a; iread = 1;
            wait_done(0, cdone, rd);
            fres.push_back('{rd, init_word(a), 1'b1, cdone});
        end
        iread = 0;
    endtask

    task automatic data_thread(input int n);
        int cdone;
        logic [31:0] a, wd, rd, expd;
        logic [3:0] be;
        bit is_wr;
        for (int k = 0; k < n; k++) begin
            a  = 32'h2000 + 32'd4 * $urandom_range(0, 7);
            wd = $urandom;
            be = 4'($urandom_range(1, 15));
            is_wr = ($urandom_range(0, 2) == 0);
            if (is_wr) gmem[a] = merge(gread(a), wd, be);
            expd = gread(a);
            daddress = a; dwritedata = wd; dbyteenable = be; dwrite = is_wr; dread = !is_wr;
            wait_done(1, cdone, rd);
            dres.push_back('{rd, expd, !is_wr, cdone});
        end
        dread = 0; dwrite = 0;
    endtask

    task automatic test_contention(input int n_i, input int n_d);
        bit exp_is_d[$];
        int fi, di, st, bad_order, bad_data;
        fi = n_i; di = n_d; st = 0;
        while (fi > 0 || di > 0) begin
            if (di > 0 && !(fi > 0 && st == MAX)) begin
                exp_is_d.push_back(1'b1); di--;
                st = (fi > 0) ? ((st < MAX) ? st + 1 : st) : 0;
            end else begin
                exp_is_d.push_back(1'b0); fi--; st = 0;
            end
        end
        rand_timing = 1;
        comp_q.delete(); fres.delete(); dres.delete();
        fork
            fetch_thread(n_i);
            data_thread(n_d);
        join
        rand_timing = 0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (comp_q.size() != n_i + n_d) begin n_fail++; $display("FAIL contention_count: got %0d want %0d", comp_q.size(), n_i + n_d); end
        bad_order = 0;
        foreach (comp_q[i]) if (i < exp_is_d.size() && comp_q[i].is_d != exp_is_d[i]) bad_order++;
        n_checks++; if (bad_order != 0) begin n_fail++; $display("FAIL contention_order: got %0d grants out of place want 0", bad_order); end
        bad_data = 0;
        foreach (fres[i]) if (fres[i].got !== fres[i].exp || fres[i].cdone < 0) bad_data++;
        foreach (dres[i]) if ((dres[i].chk && dres[i].got !== dres[i].exp) || dres[i].cdone < 0) bad_data++;
        n_checks++; if (bad_data != 0) begin n_fail++; $display("FAIL contention_data: got %0d bad responses want 0", bad_data); end
    endtask

    task automatic test_reset_midflight();
        int c0, cdone;
        logic [31:0] rd;
        cfg_wait = 0; cfg_lat = 6;
        daddress = 32'h2020; dread = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); #2;
            if (mread && !mwaitrequest) break;
        end
        @(posedge clk); #1;
        reset = 1; dread = 0;
        @(posedge clk); #1;
        reset = 0;
        n_checks++; if (mread !== 1'b0 || mwrite !== 1'b0) begin n_fail++; $display("FAIL midreset_strobes: got rd=%b wr=%b want 0 0", mread, mwrite); end
        n_checks++; if (iwaitrequest !== 1'b1 || dwaitrequest !== 1'b1 || maddress !== 32'd0) begin
            n_fail++; $display("FAIL midreset_outputs: got iw=%b dw=%b a=%h want 1 1 0", iwaitrequest, dwaitrequest, maddress); end
        comp_q.delete();
        repeat (8) @(posedge clk);
        #1;
        n_checks++; if (comp_q.size() != 0) begin n_fail++; $display("FAIL midreset_late_data: got %0d completions want 0", comp_q.size()); end
        cfg_lat = 1;
        run_one(0, 1, 0, 32'h120, 0, 0, c0, cdone, rd);
        n_checks++; if (cdone !== c0 + 2 || rd !== init_word(32'h120)) begin
            n_fail++; $display("FAIL midreset_next_fetch: got cycle %0d data %h want %0d %h", cdone, rd, c0 + 2, init_word(32'h120)); end
    endtask

    task automatic test_output_hygiene();
        n_checks++; if (bad_rdata != 0) begin n_fail++; $display("FAIL idle_readdata: got %0d nonzero idle cycles want 0", bad_rdata); end
        n_checks++; if (both_low != 0) begin n_fail++; $display("FAIL dual_complete: got %0d cycles both ports done want 0", both_low); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_back_to_back();
        test_dual_request();
        test_zero_latency();
        test_contention(4, 13);
        test_contention(5, 10);
        test_reset_midflight();
        test_output_hygiene();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
